// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and sizing for the L2 bus arbiter
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR       = 2'd2
  } l2_arb_state_t;

  // 128b line refilled over a 32b bus
  localparam int BURST_LEN = 4;
  localparam int AW        = 32;
  localparam int DW        = 32;

endpackage

// File: rtl/l2_bus_arbiter_rr_pick.sv
// rtl/l2_bus_arbiter_rr_pick.sv - round-robin winner select starting after last owner
module rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic [IW-1:0]      winner,
  output logic               any_req
);

  assign any_req = |req;

  // scan from last_owner+1 around the ring; last_owner itself is checked last
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// rtl/l2_bus_arbiter.sv - round-robin owner of the shared L2 port for refills and write-throughs
module l2_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BURST_LEN = l2_arb_pkg::BURST_LEN,
  parameter int AW        = l2_arb_pkg::AW,
  parameter int DW        = l2_arb_pkg::DW,
  localparam int IW       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_rd_en,
  input  logic [NUM_REQ-1:0]    req_wr_en,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    rd_granted,
  output logic [NUM_REQ-1:0]    wr_granted,
  output logic [AW-1:0]         l2_addr,
  output logic                  l2_rd_en,
  output logic                  l2_wr_en,
  output logic [DW-1:0]         l2_wr_data,
  input  logic                  l2_ack,
  output logic                  busy,
  output logic [IW-1:0]         owner
);

  import l2_arb_pkg::l2_arb_state_t;
  import l2_arb_pkg::IDLE;
  import l2_arb_pkg::RD_BURST;
  import l2_arb_pkg::WR;

  localparam int BW = $clog2(BURST_LEN);

  l2_arb_state_t      state;
  logic [IW-1:0]      owner_q;
  logic [IW-1:0]      last_owner;
  logic [BW-1:0]      beat_cnt;
  logic [IW-1:0]      winner;
  logic               any_req;
  logic [NUM_REQ-1:0] req_any;

  assign req_any = req_rd_en | req_wr_en;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (req_any),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign busy  = (state != IDLE);
  assign owner = owner_q;

  // port mux: only the owner is presented to L2, grants follow l2_ack in the same cycle
  always_comb begin
    rd_granted = '0;
    wr_granted = '0;
    l2_addr    = '0;
    l2_rd_en   = 1'b0;
    l2_wr_en   = 1'b0;
    l2_wr_data = '0;
    case (state)
      RD_BURST: begin
        l2_rd_en            = req_rd_en[owner_q];
        l2_addr             = req_addr[owner_q*AW +: AW];
        rd_granted[owner_q] = l2_rd_en & l2_ack;
      end
      WR: begin
        l2_wr_en            = req_wr_en[owner_q];
        l2_addr             = req_addr[owner_q*AW +: AW];
        l2_wr_data          = req_wr_data[owner_q*DW +: DW];
        wr_granted[owner_q] = l2_wr_en & l2_ack;
      end
      default: ;
    endcase
  end

  // ownership FSM: arbitrate in IDLE, hold the owner until its burst/write ends or is withdrawn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_q    <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q  <= winner;
            beat_cnt <= '0;
            // a requester asking for both gets its refill first
            state    <= req_rd_en[winner] ? RD_BURST : WR;
          end
        end
        RD_BURST: begin
          if (!req_rd_en[owner_q]) begin
            state      <= IDLE;
            last_owner <= owner_q;
            beat_cnt   <= '0;
          end else if (l2_ack) begin
            if (beat_cnt == BW'(BURST_LEN - 1)) begin
              state      <= IDLE;
              last_owner <= owner_q;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        WR: begin
          if (!req_wr_en[owner_q] || l2_ack) begin
            state      <= IDLE;
            last_owner <= owner_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb/tb_l2_bus_arbiter.sv - scoreboard bench for l2_bus_arbiter
module tb_l2_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    rd_on, wr_on;
  logic [AW-1:0]   base  [N];
  logic [DW-1:0]   wdata [N];
  int              beats [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wr_data;
  logic            l2_ack;

  logic [N-1:0]    rd_granted, wr_granted;
  logic [AW-1:0]   l2_addr;
  logic            l2_rd_en, l2_wr_en;
  logic [DW-1:0]   l2_wr_data;
  logic            busy;
  logic            owner;

  l2_bus_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_rd_en   (rd_on),
    .req_wr_en   (wr_on),
    .req_addr    (req_addr),
    .req_wr_data (req_wr_data),
    .rd_granted  (rd_granted),
    .wr_granted  (wr_granted),
    .l2_addr     (l2_addr),
    .l2_rd_en    (l2_rd_en),
    .l2_wr_en    (l2_wr_en),
    .l2_wr_data  (l2_wr_data),
    .l2_ack      (l2_ack),
    .busy        (busy),
    .owner       (owner)
  );

  // requester-side address counters
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]    = base[i] + AW'(beats[i] * 4);
      req_wr_data[i*DW +: DW] = wdata[i];
    end
  end

  typedef struct {
    bit          is_wr;
    int          idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          n_gr = 0;
  logic [N-1:0] g_rd = '0;
  logic [N-1:0] g_wr = '0;
  logic [N-1:0] one_hot;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input bit w, input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t x;
    x.is_wr = w;
    x.idx   = idx;
    x.addr  = a;
    x.data  = d;
    exp_q.push_back(x);
  endtask

  task automatic push_rd(input int idx, input logic [AW-1:0] a, input int n);
    for (int b = 0; b < n; b++) push(1'b0, idx, a + AW'(b * 4), '0);
  endtask

  // monitor: every grant seen must match the head of the expected queue
  always @(negedge clk) begin
    g_rd = rd_granted;
    g_wr = wr_granted;
    if (rst_n && ((|rd_granted) || (|wr_granted))) begin
      n_gr++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant: got rd=%b wr=%b expected none", rd_granted, wr_granted);
      end else begin
        e       = exp_q.pop_front();
        one_hot = N'(1) << e.idx;
        check("rd_granted", 64'(rd_granted), e.is_wr ? 64'(0) : 64'(one_hot));
        check("wr_granted", 64'(wr_granted), e.is_wr ? 64'(one_hot) : 64'(0));
        check("l2_addr", 64'(l2_addr), 64'(e.addr));
        check("l2_wr_data", 64'(l2_wr_data), 64'(e.data));
        check("owner", 64'(owner), 64'(e.idx));
      end
    end
  end

  // requester model: advance beat address on each grant, drop request when done
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (g_rd[i]) begin
        beats[i] = beats[i] + 1;
        if (beats[i] == 4) begin
          beats[i] = 0;
          rd_on[i] = 1'b0;
        end
      end
      if (g_wr[i]) wr_on[i] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_beats(input int idx, input int n, input int budget);
    int c;
    c = 0;
    while (beats[idx] != n && c < budget) begin
      tick();
      c++;
    end
    check("beat_wait", 64'(beats[idx]), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rd_on  = '0;
    wr_on  = '0;
    l2_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      base[i]  = '0;
      wdata[i] = '0;
      beats[i] = 0;
    end
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 64'(busy), 0);
    check("rst_owner", 64'(owner), 0);
    check("rst_l2_rd_en", 64'(l2_rd_en), 0);
    check("rst_l2_wr_en", 64'(l2_wr_en), 0);
    check("rst_l2_addr", 64'(l2_addr), 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 0);

    // single read burst by requester 0
    base[0] = 32'h0000_0100;
    push_rd(0, 32'h0000_0100, 4);
    l2_ack   = 1'b1;
    rd_on[0] = 1'b1;
    @(negedge clk); #1;
    check("no_grant_in_idle", 64'({rd_granted, wr_granted}), 0);
    @(negedge clk); #1;
    check("first_beat_cycle1", 64'(rd_granted), 64'(2'b01));
    wait_drain(20);
    check("single_rd_idle", 64'(busy), 0);

    // write-through by requester 1
    base[1]  = 32'h1000_0040;
    wdata[1] = 32'hDEAD_BEEF;
    push(1'b1, 1, 32'h1000_0040, 32'hDEAD_BEEF);
    wr_on[1] = 1'b1;
    wait_drain(20);
    check("wr_idle", 64'(busy), 0);
    check("wr_data_idle_zero", 64'(l2_wr_data), 0);

    // contention: last owner is 1, so requester 0 goes first
    base[0] = 32'h0000_0200;
    base[1] = 32'h0000_0300;
    wdata[1] = '0;
    push_rd(0, 32'h0000_0200, 4);
    push_rd(1, 32'h0000_0300, 4);
    rd_on = 2'b11;
    wait_drain(40);

    // stall three cycles after the second beat
    base[0] = 32'h0000_0400;
    n0 = n_gr;
    push_rd(0, 32'h0000_0400, 4);
    rd_on[0] = 1'b1;
    wait_beats(0, 2, 20);
    l2_ack = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #1;
      check("stall_owner", 64'(owner), 0);
      check("stall_busy", 64'(busy), 1);
      check("stall_no_grant", 64'(rd_granted), 0);
    end
    l2_ack = 1'b1;
    wait_drain(20);
    check("stall_total_grants", 64'(n_gr - n0), 4);

    // abort requester 0 after two beats; pending requester 1 follows
    base[0] = 32'h0000_0500;
    base[1] = 32'h0000_0600;
    push_rd(0, 32'h0000_0500, 2);
    push_rd(1, 32'h0000_0600, 4);
    rd_on[0] = 1'b1;
    tick();
    rd_on[1] = 1'b1;
    wait_beats(0, 2, 20);
    rd_on[0] = 1'b0;
    beats[0] = 0;
    @(negedge clk); #1;
    check("abort_rd_en_low", 64'(l2_rd_en), 0);
    @(negedge clk); #1;
    check("abort_idle", 64'(busy), 0);
    @(negedge clk); #1;
    check("abort_next_owner", 64'(owner), 1);
    wait_drain(30);

    // asynchronous reset mid-burst
    base[0] = 32'h0000_0700;
    push_rd(0, 32'h0000_0700, 1);
    rd_on[0] = 1'b1;
    wait_beats(0, 1, 20);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 0);
    check("arst_rd_granted", 64'(rd_granted), 0);
    check("arst_l2_rd_en", 64'(l2_rd_en), 0);
    check("arst_l2_addr", 64'(l2_addr), 0);
    check("arst_owner", 64'(owner), 0);
    rd_on    = '0;
    beats[0] = 0;
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #1;
      check("post_rst_idle", 64'(busy), 0);
    end

    check("queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
